// File: rtl/mcpu_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mcpu_alu_pkg
//  Description : Shared opcode constants, FSM state encoding and opcode
//                decode helper for the sequential ALU.
//  Contents    : op_t / OP_* opcode values, state_t / ST_* FSM states,
//                decode_op() which folds unused codes onto ADD.
//  Revision    : 1.0 - initial release
// ============================================================================
package mcpu_alu_pkg;

    typedef logic [3:0] op_t;

    localparam op_t OP_AND = 4'd0;
    localparam op_t OP_OR  = 4'd1;
    localparam op_t OP_XOR = 4'd2;
    localparam op_t OP_ADD = 4'd3;
    localparam op_t OP_LSL = 4'd4;
    localparam op_t OP_LSR = 4'd5;
    localparam op_t OP_SUB = 4'd6;
    localparam op_t OP_MUL = 4'd7;
    localparam op_t OP_ASR = 4'd8;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_MUL  = 1'b1;

    // Every code above ASR is treated as ADD, so the datapath only ever
    // sees the nine defined operations.
    function automatic op_t decode_op(input logic [31:0] code);
        if (code > 32'd8) begin
            return OP_ADD;
        end
        return code[3:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mcpu_mul_iter.sv
`default_nettype none
// ============================================================================
//  Module      : mcpu_mul_iter
//  Description : Iterative unsigned shift-add multiplier, one partial
//                product per clock, WORD_SIZE steps after load.
//  Ports       : clk, rst_n      - clock, synchronous active-low reset
//                load            - capture a/b and begin multiplying
//                a, b            - multiplicand / multiplier
//                last            - the final step happens on this edge
//                prod_next       - accumulator value after this step
//                                  (the full product when last=1)
//  Revision    : 1.0 - initial release
// ============================================================================
module mcpu_mul_iter #(
    parameter int WORD_SIZE = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load,
    input  logic [WORD_SIZE-1:0]     a,
    input  logic [WORD_SIZE-1:0]     b,
    output logic                     last,
    output logic [2*WORD_SIZE-1:0]   prod_next
);

    localparam int CNT_W = $clog2(WORD_SIZE);
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(WORD_SIZE - 1);

    logic [WORD_SIZE-1:0]   r_mcand;
    // Upper half accumulates partial sums, lower half starts as the
    // multiplier and is consumed one bit per step from the LSB.
    logic [2*WORD_SIZE-1:0] r_acc;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_active;

    logic [WORD_SIZE-1:0]   w_addend;
    logic [WORD_SIZE:0]     w_sum;

    always_comb begin
        w_addend  = r_acc[0] ? r_mcand : '0;
        w_sum     = {1'b0, r_acc[2*WORD_SIZE-1:WORD_SIZE]} + {1'b0, w_addend};
        prod_next = {w_sum, r_acc[WORD_SIZE-1:1]};
        last      = r_active && (r_cnt == C_LAST_CNT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (load) begin
            r_mcand  <= a;
            r_acc    <= {{WORD_SIZE{1'b0}}, b};
            r_cnt    <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            r_acc <= prod_next;
            r_cnt <= r_cnt + 1'b1;
            if (last) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mcpu_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : mcpu_seq_alu
//  Description : Sequential ALU. Logic/arith/shift ops complete one cycle
//                after acceptance; MUL runs on an iterative multiplier and
//                completes WORD_SIZE cycles after acceptance.
//  Ports       : clk, rst_n           - clock, synchronous active-low reset
//                start, cmd, in1, in2 - request, sampled on a rising edge
//                busy                 - MUL in progress
//                done                 - one-cycle result-valid pulse
//                out, out_hi          - result low word / MUL high word
//                CF, ZF, NF, VF       - carry, zero, negative, overflow
//  Revision    : 1.0 - initial release
// ============================================================================
module mcpu_seq_alu
    import mcpu_alu_pkg::*;
#(
    parameter int WORD_SIZE = 16,
    parameter int CMD_SIZE  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CMD_SIZE-1:0]   cmd,
    input  logic [WORD_SIZE-1:0]  in1,
    input  logic [WORD_SIZE-1:0]  in2,
    output logic                  busy,
    output logic                  done,
    output logic [WORD_SIZE-1:0]  out,
    output logic [WORD_SIZE-1:0]  out_hi,
    output logic                  CF,
    output logic                  ZF,
    output logic                  NF,
    output logic                  VF
);

    localparam int                   MSB         = WORD_SIZE - 1;
    localparam logic [WORD_SIZE-1:0] C_WORD_BITS = WORD_SIZE'(WORD_SIZE);

    state_t r_state, w_state_next;

    logic w_accept, w_accept_mul, w_accept_single;
    op_t  w_in_op;

    // Single-cycle ops are captured here and executed on the next edge,
    // so a new request can be accepted every cycle while IDLE.
    logic                 r_pend;
    op_t                  r_op;
    logic [WORD_SIZE-1:0] r_a, r_b;

    logic [WORD_SIZE-1:0] r_out, r_out_hi;
    logic                 r_done, r_cf, r_zf, r_nf, r_vf;

    logic [WORD_SIZE-1:0]   w_res;
    logic [WORD_SIZE:0]     w_sum;
    logic                   w_cf, w_vf, w_big;
    logic                   w_mul_last;
    logic [2*WORD_SIZE-1:0] w_prod;

    mcpu_mul_iter #(
        .WORD_SIZE (WORD_SIZE)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_accept_mul),
        .a         (in1),
        .b         (in2),
        .last      (w_mul_last),
        .prod_next (w_prod)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept_mul) w_state_next = ST_MUL;
            ST_MUL:  if (w_mul_last)   w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy            = (r_state == ST_MUL);
        w_accept        = start && (r_state == ST_IDLE);
        w_in_op         = decode_op(32'(cmd));
        w_accept_mul    = w_accept && (w_in_op == OP_MUL);
        w_accept_single = w_accept && (w_in_op != OP_MUL);
    end

    // ---------------- single-cycle datapath ----------------
    always_comb begin
        w_res = '0;
        w_sum = '0;
        w_cf  = 1'b0;
        w_vf  = 1'b0;
        w_big = (r_b >= C_WORD_BITS);
        case (r_op)
            OP_AND: w_res = r_a & r_b;
            OP_OR:  w_res = r_a | r_b;
            OP_XOR: w_res = r_a ^ r_b;
            OP_LSL: w_res = w_big ? '0 : (r_a << r_b);
            OP_LSR: w_res = w_big ? '0 : (r_a >> r_b);
            OP_ASR: w_res = w_big ? {WORD_SIZE{r_a[MSB]}} : ($signed(r_a) >>> r_b);
            OP_SUB: begin
                w_res = r_a - r_b;
                w_cf  = (r_a < r_b);
                w_vf  = (r_a[MSB] ^ r_b[MSB]) & (w_res[MSB] ^ r_a[MSB]);
            end
            default: begin
                w_sum = {1'b0, r_a} + {1'b0, r_b};
                w_res = w_sum[MSB:0];
                w_cf  = w_sum[WORD_SIZE];
                w_vf  = ~(r_a[MSB] ^ r_b[MSB]) & (w_res[MSB] ^ r_a[MSB]);
            end
        endcase
    end

    // ---------------- capture and result registers ----------------
    // r_pend and w_mul_last are never high together: a pending single op
    // implies the FSM was IDLE on the previous edge and did not start MUL.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend   <= 1'b0;
            r_op     <= OP_AND;
            r_a      <= '0;
            r_b      <= '0;
            r_done   <= 1'b0;
            r_out    <= '0;
            r_out_hi <= '0;
            r_cf     <= 1'b0;
            r_zf     <= 1'b0;
            r_nf     <= 1'b0;
            r_vf     <= 1'b0;
        end else begin
            r_pend <= w_accept_single;
            r_done <= 1'b0;
            if (w_accept_single) begin
                r_op <= w_in_op;
                r_a  <= in1;
                r_b  <= in2;
            end
            if (r_pend) begin
                r_done   <= 1'b1;
                r_out    <= w_res;
                r_out_hi <= '0;
                r_cf     <= w_cf;
                r_zf     <= (w_res == '0);
                r_nf     <= w_res[MSB];
                r_vf     <= w_vf;
            end else if (w_mul_last) begin
                r_done   <= 1'b1;
                r_out    <= w_prod[MSB:0];
                r_out_hi <= w_prod[2*WORD_SIZE-1:WORD_SIZE];
                r_cf     <= |w_prod[2*WORD_SIZE-1:WORD_SIZE];
                r_zf     <= (w_prod == '0);
                r_nf     <= w_prod[MSB];
                r_vf     <= 1'b0;
            end
        end
    end

    assign done   = r_done;
    assign out    = r_out;
    assign out_hi = r_out_hi;
    assign CF     = r_cf;
    assign ZF     = r_zf;
    assign NF     = r_nf;
    assign VF     = r_vf;

endmodule
`default_nettype wire

// File: tb/tb_mcpu_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mcpu_seq_alu
//  Description : Self-checking bench for mcpu_seq_alu (WORD_SIZE=16):
//                directed vector table, multi-cycle corner sequences and
//                randomized ops against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mcpu_seq_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  cmd = 4'd0;
    logic [15:0] in1 = 16'd0;
    logic [15:0] in2 = 16'd0;
    logic        busy, done, CF, ZF, NF, VF;
    logic [15:0] out, out_hi;

    int checks = 0;
    int errors = 0;

    mcpu_seq_alu #(
        .WORD_SIZE (16),
        .CMD_SIZE  (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cmd    (cmd),
        .in1    (in1),
        .in2    (in2),
        .busy   (busy),
        .done   (done),
        .out    (out),
        .out_hi (out_hi),
        .CF     (CF),
        .ZF     (ZF),
        .NF     (NF),
        .VF     (VF)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic; flags from value ranges.
    function automatic void model(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] lo, output logic [15:0] hi,
                                  output logic [3:0] fl);
        longint ua, ub, sa, sb, r;
        int     op;
        logic   cf, vf;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        op = (c > 4'd8) ? 3 : int'(c);
        lo = 16'd0; hi = 16'd0; cf = 1'b0; vf = 1'b0; r = 0;
        case (op)
            0: lo = a & b;
            1: lo = a | b;
            2: lo = a ^ b;
            3: begin
                r = ua + ub; lo = r[15:0]; cf = (r > 65535);
                r = sa + sb; vf = (r > 32767) || (r < -32768);
            end
            6: begin
                r = ua - ub; lo = r[15:0]; cf = (ua < ub);
                r = sa - sb; vf = (r > 32767) || (r < -32768);
            end
            4: begin r = (ub >= 16) ? 0 : (ua << ub); lo = r[15:0]; end
            5: begin r = (ub >= 16) ? 0 : (ua >> ub); lo = r[15:0]; end
            8: begin r = (ub >= 16) ? ((sa < 0) ? -1 : 0) : (sa >>> ub); lo = r[15:0]; end
            default: begin
                r = ua * ub; lo = r[15:0]; hi = r[31:16]; cf = (hi != 16'd0);
            end
        endcase
        fl = {cf, (lo == 16'd0) && (hi == 16'd0), lo[15], vf};
    endfunction

    // Issue one op, wait for done, check result, flags, latency and busy.
    task automatic run_op(input string tag, input logic [3:0] c, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] e_lo,
                          input logic [15:0] e_hi, input logic [3:0] e_fl);
        int lat, bcnt, e_lat;
        e_lat = (c == 4'd7) ? 16 : 1;
        lat = 0;
        bcnt = 0;
        start = 1'b1; cmd = c; in1 = a; in2 = b;
        @(posedge clk); #1;
        start = 1'b0; in1 = 16'($urandom); in2 = 16'($urandom); cmd = 4'($urandom);
        for (int i = 1; i <= 40; i++) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        chk({tag, ".latency"}, 64'(lat), 64'(e_lat));
        chk({tag, ".out"}, 64'(out), 64'(e_lo));
        chk({tag, ".out_hi"}, 64'(out_hi), 64'(e_hi));
        chk({tag, ".flags_CZNV"}, 64'({CF, ZF, NF, VF}), 64'(e_fl));
        chk({tag, ".busy_cycles"}, 64'(bcnt), 64'((c == 4'd7) ? 16 : 0));
        chk({tag, ".busy_at_done"}, 64'(busy), 64'(0));
    endtask

    typedef struct {
        logic [3:0]  c;
        logic [15:0] a, b, e_lo, e_hi;
        logic [3:0]  e_fl;   // {CF, ZF, NF, VF}
    } vec_t;

    vec_t vecs[17];

    initial begin
        int          n_done, lat;
        logic [15:0] m_lo, m_hi, ra, rb;
        logic [3:0]  m_fl, rc;

        vecs[0]  = '{4'd3,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 4'b1100};
        vecs[1]  = '{4'd6,  16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 4'b0001};
        vecs[2]  = '{4'd6,  16'h0001, 16'h0002, 16'hFFFF, 16'h0000, 4'b1010};
        vecs[3]  = '{4'd7,  16'h1234, 16'h0100, 16'h3400, 16'h0012, 4'b1000};
        vecs[4]  = '{4'd0,  16'hF0F0, 16'h3C3C, 16'h3030, 16'h0000, 4'b0000};
        vecs[5]  = '{4'd8,  16'h8000, 16'd20,   16'hFFFF, 16'h0000, 4'b0010};
        vecs[6]  = '{4'd4,  16'h0001, 16'd16,   16'h0000, 16'h0000, 4'b0100};
        vecs[7]  = '{4'd1,  16'h00F0, 16'h0F00, 16'h0FF0, 16'h0000, 4'b0000};
        vecs[8]  = '{4'd2,  16'hAAAA, 16'hAAAA, 16'h0000, 16'h0000, 4'b0100};
        vecs[9]  = '{4'd5,  16'h8000, 16'd15,   16'h0001, 16'h0000, 4'b0000};
        vecs[10] = '{4'd4,  16'h1234, 16'd0,    16'h1234, 16'h0000, 4'b0000};
        vecs[11] = '{4'd9,  16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 4'b0011};
        vecs[12] = '{4'd15, 16'h0001, 16'h0002, 16'h0003, 16'h0000, 4'b0000};
        vecs[13] = '{4'd7,  16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 4'b1000};
        vecs[14] = '{4'd7,  16'h0000, 16'h1234, 16'h0000, 16'h0000, 4'b0100};
        vecs[15] = '{4'd8,  16'h4000, 16'd1,    16'h2000, 16'h0000, 4'b0000};
        vecs[16] = '{4'd5,  16'h8000, 16'd16,   16'h0000, 16'h0000, 4'b0100};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset.out", 64'(out), 64'(0));
        chk("reset.out_hi", 64'(out_hi), 64'(0));
        chk("reset.flags", 64'({CF, ZF, NF, VF}), 64'(0));
        chk("reset.busy", 64'(busy), 64'(0));
        chk("reset.done", 64'(done), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed table; consecutive entries are issued back-to-back,
        // including an AND in the done cycle of a MUL (entries 3 -> 4).
        for (int i = 0; i < 17; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].c, vecs[i].a, vecs[i].b,
                   vecs[i].e_lo, vecs[i].e_hi, vecs[i].e_fl);
        end

        // start while MUL is busy must be ignored
        start = 1'b1; cmd = 4'd7; in1 = 16'd3; in2 = 16'd5;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        n_done = 0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 4) begin
                start = 1'b1; cmd = 4'd0; in1 = 16'hFFFF; in2 = 16'hFFFF;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                lat = i;
                break;
            end
        end
        chk("midmul.latency", 64'(lat), 64'(16));
        chk("midmul.out", 64'(out), 64'(16'h000F));
        chk("midmul.out_hi", 64'(out_hi), 64'(0));
        repeat (3) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        chk("midmul.no_extra_done", 64'(n_done), 64'(0));
        chk("midmul.hold_out", 64'(out), 64'(16'h000F));

        // Reset during cycle 5 of a MUL, with start asserted in the reset cycle
        start = 1'b1; cmd = 4'd7; in1 = 16'h1234; in2 = 16'h0100;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0; start = 1'b1; cmd = 4'd3; in1 = 16'h0001; in2 = 16'h0001;
        @(posedge clk); #1;
        rst_n = 1'b1; start = 1'b0;
        chk("rstmul.out", 64'(out), 64'(0));
        chk("rstmul.out_hi", 64'(out_hi), 64'(0));
        chk("rstmul.flags", 64'({CF, ZF, NF, VF}), 64'(0));
        chk("rstmul.busy", 64'(busy), 64'(0));
        chk("rstmul.done", 64'(done), 64'(0));
        n_done = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        chk("rstmul.no_done", 64'(n_done), 64'(0));
        run_op("postrst_add", 4'd3, 16'h0005, 16'h0003, 16'h0008, 16'h0000, 4'b0000);

        // Randomized ops, every one issued back-to-back with the previous
        for (int i = 0; i < 60; i++) begin
            rc = 4'($urandom_range(0, 15));
            ra = 16'($urandom);
            if ($urandom_range(0, 2) == 0) rb = 16'($urandom);
            else                           rb = 16'($urandom_range(0, 20));
            model(rc, ra, rb, m_lo, m_hi, m_fl);
            run_op($sformatf("rnd%0d_cmd%0d", i, rc), rc, ra, rb, m_lo, m_hi, m_fl);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mcpu_seq_alu.md
MCPU_SEQ_ALU -- requirements
Module: mcpu_seq_alu

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 16, meaning operand/result width (>=4).
REQ-002 The block SHALL have parameter CMD_SIZE, default 4, meaning opcode width.
REQ-003 The block SHALL have port clk  in  1  the single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port start  in  1  request; sampled with cmd/in1/in2 on a rising edge.
REQ-006 The block SHALL have port cmd  in  CMD_SIZE  opcode.
REQ-007 The block SHALL have ports in1, in2  in  WORD_SIZE  operands.
REQ-008 The block SHALL have port busy  out  1  multi-cycle operation in progress.
REQ-009 The block SHALL have port done  out  1  one-cycle pulse; result and flags valid.
REQ-010 The block SHALL have port out  out  WORD_SIZE  result, low word.
REQ-011 The block SHALL have port out_hi  out  WORD_SIZE  high word of the MUL product; 0 for all other ops.
REQ-012 The block SHALL have ports CF, ZF, NF, VF  out  1 each  carry, zero, negative, signed-overflow flags.

Function
REQ-013 The opcodes SHALL be AND=0, OR=1, XOR=2, ADD=3, LSL=4, LSR=5, SUB=6, MUL=7, ASR=8; codes 9..max SHALL execute as ADD.
REQ-014 The FSM SHALL have states IDLE and MUL; start is accepted only in IDLE; start while busy SHALL be ignored.
REQ-015 Single-cycle ops accepted at edge k SHALL register out, out_hi and flags at edge k+1, with done=1 for that one cycle and busy=0 throughout.
REQ-016 MUL accepted at edge k SHALL move to MUL, set busy=1 and do one shift-add iteration per cycle; at edge k+WORD_SIZE it SHALL present {out_hi,out}=in1*in2 (unsigned, 2*WORD_SIZE bits), set done=1 and busy=0, and return to IDLE.
REQ-017 Operands and cmd SHALL be captured at acceptance; input changes during MUL SHALL not affect the result.
REQ-018 start in the cycle done=1 SHALL be accepted (back-to-back, no bubble).
REQ-019 out, out_hi and flags SHALL hold their last values until the next done.
REQ-020 ADD: {CF,out}=in1+in2; VF=1 when operands share a sign and the result sign differs.
REQ-021 SUB: out=in1-in2 mod 2^WORD_SIZE; CF=1 when in1<in2 unsigned (borrow); VF=1 when operand signs differ and the result sign differs from in1.
REQ-022 LSL/LSR/ASR: shift amount=in2 unsigned; amount>=WORD_SIZE SHALL give 0 (LSL/LSR) or all-sign-bits (ASR); amount 0 SHALL pass in1 unchanged.
REQ-023 AND/OR/XOR/shifts SHALL set CF=0 and VF=0; MUL SHALL set CF=|out_hi and VF=0.
REQ-024 ZF SHALL be 1 iff the full result ({out_hi,out} for MUL) is zero; NF SHALL equal out[WORD_SIZE-1].

Reset
REQ-025 rst_n=0 at a rising edge SHALL force IDLE, busy=0, done=0, out=0, out_hi=0, and all flags 0.
REQ-026 Reset during MUL SHALL abort it with no done pulse; start sampled in a reset cycle SHALL be ignored.

Structure
REQ-027 Opcode constants and the FSM state encoding SHALL reside in shared package mcpu_alu_pkg.
REQ-028 The iterative multiplier SHALL be a sub-module mcpu_mul_iter (load, one step per cycle, done after WORD_SIZE steps).

Verification (WORD_SIZE=16)
REQ-029 ADD 0xFFFF+0x0001 -> out=0x0000, CF=1, ZF=1, VF=0, done at k+1.
REQ-030 SUB 0x8000-0x0001 -> out=0x7FFF, CF=0, VF=1, NF=0; SUB 0x0001-0x0002 -> out=0xFFFF, CF=1, NF=1.
REQ-031 MUL 0x1234*0x0100 -> out_hi=0x0012, out=0x3400, CF=1, busy high 16 cycles, done at k+16; start mid-MUL is ignored.
REQ-032 ASR 0x8000 by 20 -> out=0xFFFF; LSL 0x0001 by 16 -> out=0x0000, ZF=1.
REQ-033 Reset at cycle 5 of a MUL -> no done pulse, all outputs 0; an ADD issued after reset completes normally.
REQ-034 Back-to-back: AND issued in the MUL done cycle -> AND done one cycle later with correct result.
